// File: rtl/load_store_unit.sv
// Load/store unit: one memory op at a time over a req/gnt/rvalid data bus.
// Formats store lanes and load results, stalls the pipe, reports faults.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

  // Last counter value before the wait is abandoned.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  state_t      state_next;

  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [2:0]  funct3_q;
  logic        write_q;
  logic [7:0]  cnt_q;
  logic        fault_q;
  logic [1:0]  cause_q;

  logic        accept;
  logic        illegal;
  logic        misaligned;
  logic        bad_op;
  logic        timeout;
  logic        plain_load;

  logic [3:0]  be_fmt;
  logic [31:0] wdata_fmt;
  logic [31:0] lane;
  logic [31:0] load_fmt;

  assign accept     = req_valid & (mem_read | mem_write);
  assign plain_load = mem_read & ~mem_write;
  assign bad_op     = illegal | misaligned;
  assign timeout    = (cnt_q == CNT_LAST);

  // Classify the incoming op: unsupported encodings and bad alignment.
  always_comb begin
    illegal = 1'b0;
    if (mem_read && mem_write) begin
      illegal = 1'b1;
    end else if (mem_read) begin
      illegal = (funct3 == 3'b011) ||
                (funct3 == 3'b110) ||
                (funct3 == 3'b111);
    end else if (mem_write) begin
      illegal = funct3[2];
    end
    misaligned = 1'b0;
    if (funct3[1:0] == 2'b01) begin
      misaligned = addr[0];
    end else if (funct3[1]) begin
      misaligned = (addr[1:0] != 2'b00);
    end
  end

  // Byte enables and replicated store data from the latched op.
  always_comb begin
    be_fmt    = 4'b1111;
    wdata_fmt = wdata_q;
    unique case (funct3_q[1:0])
      2'b00: begin
        be_fmt    = 4'b0001 << addr_q[1:0];
        wdata_fmt = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be_fmt    = 4'b0011 << {addr_q[1], 1'b0};
        wdata_fmt = {2{wdata_q[15:0]}};
      end
      default: begin
        be_fmt    = 4'b1111;
        wdata_fmt = wdata_q;
      end
    endcase
  end

  // Shift the addressed lane down and extend it to 32 bits.
  always_comb begin
    lane     = bus_rdata >> {addr_q[1:0], 3'b000};
    load_fmt = lane;
    unique case (funct3_q)
      3'b000:  load_fmt = {{24{lane[7]}}, lane[7:0]};
      3'b100:  load_fmt = {24'd0, lane[7:0]};
      3'b001:  load_fmt = {{16{lane[15]}}, lane[15:0]};
      3'b101:  load_fmt = {16'd0, lane[15:0]};
      default: load_fmt = lane;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_next = bad_op ? DONE : REQ;
        end
      end
      REQ: begin
        if (bus_gnt) begin
          state_next = write_q ? DONE : WAIT_RSP;
        end else if (timeout) begin
          state_next = DONE;
        end
      end
      WAIT_RSP: begin
        if (bus_rvalid || timeout) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand latch, wait counter, fault status and load result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      funct3_q <= 3'd0;
      write_q  <= 1'b0;
      cnt_q    <= 8'd0;
      fault_q  <= 1'b0;
      cause_q  <= CAUSE_NONE;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            addr_q   <= addr;
            wdata_q  <= wdata;
            funct3_q <= funct3;
            write_q  <= mem_write;
            cnt_q    <= 8'd0;
            fault_q  <= bad_op;
            if (illegal) begin
              cause_q <= CAUSE_ILLEGAL;
            end else if (misaligned) begin
              cause_q <= CAUSE_MISALIGN;
            end else begin
              cause_q <= CAUSE_NONE;
            end
            if (bad_op && plain_load) begin
              rdata_q <= 32'd0;
            end
          end
        end
        REQ: begin
          if (bus_gnt) begin
            cnt_q <= 8'd0;
          end else if (timeout) begin
            fault_q <= 1'b1;
            cause_q <= CAUSE_TIMEOUT;
            if (!write_q) begin
              rdata_q <= 32'd0;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        WAIT_RSP: begin
          if (bus_rvalid) begin
            rdata_q <= load_fmt;
          end else if (timeout) begin
            fault_q <= 1'b1;
            cause_q <= CAUSE_TIMEOUT;
            rdata_q <= 32'd0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs decoded from state; bus fields only driven while requesting.
  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    fault       = 1'b0;
    fault_cause = CAUSE_NONE;
    rdata       = rdata_q;
    bus_req     = 1'b0;
    bus_we      = 1'b0;
    bus_addr    = 32'd0;
    bus_be      = 4'd0;
    bus_wdata   = 32'd0;
    unique case (state)
      IDLE: begin
        busy = accept;
      end
      REQ: begin
        busy      = 1'b1;
        bus_req   = 1'b1;
        bus_we    = write_q;
        bus_addr  = {addr_q[31:2], 2'b00};
        bus_be    = be_fmt;
        bus_wdata = write_q ? wdata_fmt : 32'd0;
      end
      WAIT_RSP: begin
        busy = 1'b1;
      end
      DONE: begin
        done        = 1'b1;
        fault       = fault_q;
        fault_cause = cause_q;
      end
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: scripted bus responder per op,
// expected completions queued at issue and checked at done.
module tb_load_store_unit;

  localparam int TO    = 16;
  localparam int LIMIT = 60;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        fault;
  logic [1:0]  fault_cause;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt = 1'b0;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = 32'd0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata),
    .fault(fault), .fault_cause(fault_cause),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  typedef struct {
    int          lat;
    logic [31:0] rdata;
    logic        fault;
    logic [1:0]  cause;
    logic        chk_rdata;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] last_rdata = 32'd0;

  int          obs_lat;
  logic        obs_done;
  logic [31:0] obs_rdata;
  logic        obs_fault;
  logic [1:0]  obs_cause;
  logic        obs_busy_acc;
  logic        obs_busy_done;
  logic        obs_req_seen;
  logic        obs_unstable;
  logic [68:0] obs_fields;

  // Issue one op from IDLE and play the bus side until done or LIMIT.
  task automatic do_op(input logic rd, input logic wr,
                       input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int gnt_wait,
                       input int rv_wait, input logic [31:0] rsp);
    int n_req;
    int gcyc;
    @(negedge clk);
    req_valid = 1'b1;
    mem_read  = rd;
    mem_write = wr;
    funct3    = f3;
    addr      = a;
    wdata     = wd;
    #1 obs_busy_acc = busy;
    n_req = 0;
    gcyc = -1;
    obs_done = 1'b0;
    obs_req_seen = 1'b0;
    obs_unstable = 1'b0;
    obs_fields = '0;
    obs_lat = 0;
    for (int c = 1; c <= LIMIT; c++) begin
      @(negedge clk);
      req_valid  = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      bus_gnt    = 1'b0;
      bus_rvalid = 1'b0;
      obs_lat    = c;
      if (done) begin
        obs_done      = 1'b1;
        obs_rdata     = rdata;
        obs_fault     = fault;
        obs_cause     = fault_cause;
        obs_busy_done = busy;
        break;
      end
      if (bus_req) begin
        if (!obs_req_seen) begin
          obs_fields = {bus_we, bus_addr, bus_be, bus_wdata};
        end else if (obs_fields !== {bus_we, bus_addr, bus_be, bus_wdata}) begin
          obs_unstable = 1'b1;
        end
        obs_req_seen = 1'b1;
        n_req++;
        if (gnt_wait >= 0 && n_req == gnt_wait + 1) begin
          bus_gnt = 1'b1;
          gcyc = c;
        end
      end
      if (gcyc > 0 && rv_wait >= 0 && c == gcyc + 1 + rv_wait) begin
        bus_rvalid = 1'b1;
        bus_rdata  = rsp;
      end else begin
        bus_rdata  = $urandom;
      end
    end
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if ({busy, done, fault, fault_cause, bus_req, bus_we, bus_be} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_ctl got %b want 0", {busy, done, fault, fault_cause, bus_req, bus_we, bus_be});
    end
    n_checks++;
    if ({rdata, bus_addr, bus_wdata} !== 96'd0) begin
      n_fail++;
      $display("FAIL reset_data got %h %h %h want 0", rdata, bus_addr, bus_wdata);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_loads();
    logic [2:0]  f3s [5] = '{3'b000, 3'b101, 3'b001, 3'b100, 3'b010};
    logic [31:0] as  [5] = '{32'h1003, 32'h2002, 32'h2002, 32'h1003, 32'h3000};
    logic [31:0] rsp [5] = '{32'h80AABBCC, 32'h9ABC1234, 32'h9ABC1234, 32'h80AABBCC, 32'hDEADBEEF};
    logic [31:0] ex  [5] = '{32'hFFFFFF80, 32'h00009ABC, 32'hFFFF9ABC, 32'h00000080, 32'hDEADBEEF};
    logic [3:0]  bes [5] = '{4'b1000, 4'b1100, 4'b1100, 4'b1000, 4'b1111};
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      sb.push_back('{lat: 3, rdata: ex[i], fault: 1'b0, cause: 2'b00, chk_rdata: 1'b1});
      last_rdata = ex[i];
      do_op(1'b1, 1'b0, f3s[i], as[i], 32'h5555AAAA, 0, 0, rsp[i]);
      e = sb.pop_front();
      n_checks++;
      if (!obs_done || obs_lat !== e.lat) begin
        n_fail++;
        $display("FAIL load%0d_latency got %0d (done=%b) want %0d", i, obs_lat, obs_done, e.lat);
      end
      n_checks++;
      if (obs_rdata !== e.rdata || {obs_fault, obs_cause} !== {e.fault, e.cause}) begin
        n_fail++;
        $display("FAIL load%0d_result got %h f=%b c=%b want %h f=%b c=%b", i, obs_rdata, obs_fault, obs_cause, e.rdata, e.fault, e.cause);
      end
      n_checks++;
      if (obs_fields !== {1'b0, as[i] & 32'hFFFFFFFC, bes[i], 32'd0}) begin
        n_fail++;
        $display("FAIL load%0d_bus got %h want %h", i, obs_fields, {1'b0, as[i] & 32'hFFFFFFFC, bes[i], 32'd0});
      end
    end
  endtask

  task automatic test_stores();
    exp_t e;
    sb.push_back('{lat: 5, rdata: last_rdata, fault: 1'b0, cause: 2'b00, chk_rdata: 1'b1});
    do_op(1'b0, 1'b1, 3'b000, 32'h10, 32'h123456EF, 3, -1, 32'd0);
    e = sb.pop_front();
    n_checks++;
    if (!obs_done || obs_lat !== e.lat || obs_fault !== e.fault) begin
      n_fail++;
      $display("FAIL sb_done got lat=%0d done=%b fault=%b want lat=%0d", obs_lat, obs_done, obs_fault, e.lat);
    end
    n_checks++;
    if (obs_fields !== {1'b1, 32'h10, 4'b0001, 32'hEFEFEFEF} || obs_unstable !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_bus got %h unstable=%b want %h", obs_fields, obs_unstable, {1'b1, 32'h10, 4'b0001, 32'hEFEFEFEF});
    end
    n_checks++;
    if (obs_busy_done !== 1'b0 || obs_busy_acc !== 1'b1 || obs_rdata !== e.rdata) begin
      n_fail++;
      $display("FAIL sb_busy_rdata got busy_done=%b busy_acc=%b rdata=%h want 0 1 %h", obs_busy_done, obs_busy_acc, obs_rdata, e.rdata);
    end
    sb.push_back('{lat: 2, rdata: last_rdata, fault: 1'b0, cause: 2'b00, chk_rdata: 1'b1});
    do_op(1'b0, 1'b1, 3'b001, 32'h22, 32'hAAAA5678, 0, -1, 32'd0);
    e = sb.pop_front();
    n_checks++;
    if (!obs_done || obs_lat !== e.lat || obs_rdata !== e.rdata) begin
      n_fail++;
      $display("FAIL sh_done got lat=%0d rdata=%h want lat=%0d rdata=%h", obs_lat, obs_rdata, e.lat, e.rdata);
    end
    n_checks++;
    if (obs_fields !== {1'b1, 32'h20, 4'b1100, 32'h56785678}) begin
      n_fail++;
      $display("FAIL sh_bus got %h want %h", obs_fields, {1'b1, 32'h20, 4'b1100, 32'h56785678});
    end
  endtask

  task automatic test_faults();
    logic        rds [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic        wrs [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0]  f3s [5] = '{3'b010, 3'b001, 3'b010, 3'b011, 3'b100};
    logic [31:0] as  [5] = '{32'h6, 32'h5, 32'h0, 32'h0, 32'h0};
    logic [1:0]  cs  [5] = '{2'b01, 2'b01, 2'b11, 2'b11, 2'b11};
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      if (rds[i] && !wrs[i]) last_rdata = 32'd0;
      sb.push_back('{lat: 1, rdata: last_rdata, fault: 1'b1, cause: cs[i], chk_rdata: !(rds[i] && wrs[i])});
      do_op(rds[i], wrs[i], f3s[i], as[i], 32'hFFFFFFFF, 0, 0, 32'h0);
      e = sb.pop_front();
      n_checks++;
      if (!obs_done || obs_lat !== e.lat || obs_req_seen !== 1'b0 || obs_busy_acc !== 1'b1) begin
        n_fail++;
        $display("FAIL fault%0d_timing got lat=%0d done=%b req=%b busy=%b want lat=1 req=0 busy=1", i, obs_lat, obs_done, obs_req_seen, obs_busy_acc);
      end
      n_checks++;
      if ({obs_fault, obs_cause} !== {e.fault, e.cause}) begin
        n_fail++;
        $display("FAIL fault%0d_cause got f=%b c=%b want f=%b c=%b", i, obs_fault, obs_cause, e.fault, e.cause);
      end
      if (e.chk_rdata) begin
        n_checks++;
        if (obs_rdata !== e.rdata) begin
          n_fail++;
          $display("FAIL fault%0d_rdata got %h want %h", i, obs_rdata, e.rdata);
        end
      end
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    sb.push_back('{lat: 3, rdata: 32'h11223344, fault: 1'b0, cause: 2'b00, chk_rdata: 1'b1});
    do_op(1'b1, 1'b0, 3'b010, 32'h44, 32'h0, 0, 0, 32'h11223344);
    e = sb.pop_front();
    n_checks++;
    if (!obs_done || obs_rdata !== e.rdata || obs_lat !== e.lat) begin
      n_fail++;
      $display("FAIL lw_pre got rdata=%h lat=%0d want %h %0d", obs_rdata, obs_lat, e.rdata, e.lat);
    end
    sb.push_back('{lat: 2 + TO, rdata: 32'd0, fault: 1'b1, cause: 2'b10, chk_rdata: 1'b1});
    do_op(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 0, -1, 32'h0);
    e = sb.pop_front();
    n_checks++;
    if (!obs_done || obs_lat !== e.lat) begin
      n_fail++;
      $display("FAIL timeout_latency got %0d (done=%b) want %0d", obs_lat, obs_done, e.lat);
    end
    n_checks++;
    if ({obs_fault, obs_cause} !== {e.fault, e.cause} || obs_rdata !== e.rdata) begin
      n_fail++;
      $display("FAIL timeout_result got f=%b c=%b rdata=%h want f=1 c=10 rdata=0", obs_fault, obs_cause, obs_rdata);
    end
    @(negedge clk);
    bus_rvalid = 1'b1;
    bus_rdata  = 32'hFFFFFFFF;
    @(negedge clk);
    bus_rvalid = 1'b0;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL late_rvalid got done=%b busy=%b rdata=%h want 0 0 0", done, busy, rdata);
    end
    sb.push_back('{lat: 3, rdata: 32'h55667788, fault: 1'b0, cause: 2'b00, chk_rdata: 1'b1});
    do_op(1'b1, 1'b0, 3'b010, 32'h48, 32'h0, 0, 0, 32'h55667788);
    e = sb.pop_front();
    n_checks++;
    if (!obs_done || obs_rdata !== e.rdata || obs_lat !== e.lat || obs_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL lw_after_timeout got rdata=%h lat=%0d f=%b want %h %0d 0", obs_rdata, obs_lat, obs_fault, e.rdata, e.lat);
    end
  endtask

  task automatic test_reset_mid();
    int spurious;
    @(negedge clk);
    req_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
    funct3 = 3'b010; addr = 32'h80;
    @(negedge clk);
    req_valid = 1'b0; mem_read = 1'b0;
    n_checks++;
    if (bus_req !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_req_pre got bus_req=%b want 1", bus_req);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({bus_req, busy, done} !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_in_req got req/busy/done=%b want 000", {bus_req, busy, done});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; mem_read = 1'b1;
    funct3 = 3'b010; addr = 32'h84;
    @(negedge clk);
    req_valid = 1'b0; mem_read = 1'b0;
    bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || bus_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_wait_pre got busy=%b bus_req=%b want 1 0", busy, bus_req);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({bus_req, busy, done} !== 3'b000 || rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL rst_in_wait got req/busy/done=%b rdata=%h want 000 0", {bus_req, busy, done}, rdata);
    end
    last_rdata = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    spurious = 0;
    for (int i = 0; i < 4; i++) begin
      bus_rvalid = (i == 0);
      @(negedge clk);
      if (done !== 1'b0 || bus_req !== 1'b0) spurious++;
    end
    bus_rvalid = 1'b0;
    n_checks++;
    if (spurious != 0) begin
      n_fail++;
      $display("FAIL rst_abandon got %0d cycles with done/bus_req want 0", spurious);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    sb.push_back('{lat: 2, rdata: 32'd0, fault: 1'b0, cause: 2'b00, chk_rdata: 1'b1});
    sb.push_back('{lat: 3, rdata: 32'hCAFEF00D, fault: 1'b0, cause: 2'b00, chk_rdata: 1'b1});
    do_op(1'b0, 1'b1, 3'b010, 32'h100, 32'hCAFEF00D, 0, -1, 32'h0);
    e = sb.pop_front();
    n_checks++;
    if (!obs_done || obs_lat !== e.lat || obs_fault !== e.fault || obs_rdata !== e.rdata) begin
      n_fail++;
      $display("FAIL b2b_sw got lat=%0d f=%b rdata=%h want %0d 0 %h", obs_lat, obs_fault, obs_rdata, e.lat, e.rdata);
    end
    n_checks++;
    if (obs_fields !== {1'b1, 32'h100, 4'b1111, 32'hCAFEF00D}) begin
      n_fail++;
      $display("FAIL b2b_sw_bus got %h want %h", obs_fields, {1'b1, 32'h100, 4'b1111, 32'hCAFEF00D});
    end
    do_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0, 1, 32'hCAFEF00D);
    e = sb.pop_front();
    e.lat = e.lat + 1;
    n_checks++;
    if (!obs_done || obs_lat !== e.lat || obs_rdata !== e.rdata || obs_fault !== e.fault) begin
      n_fail++;
      $display("FAIL b2b_lw got lat=%0d f=%b rdata=%h want %0d 0 %h", obs_lat, obs_fault, obs_rdata, e.lat, e.rdata);
    end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_faults();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_left got %0d entries want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-side responder to the decoder's mem_read / mem_write / funct3 controls.
- Takes one load or store per request from the execute stage and runs it on a single-outstanding data-bus handshake (req/gnt, then rvalid).
- Formats stores (byte-lane replication, byte enables) and load data (lane extraction, sign/zero extension).
- Stalls the pipeline while the access is in flight; reports misaligned, illegal and timed-out accesses.

Parameters:
TIMEOUT_CYCLES, 16, cycles allowed in REQ or in WAIT_RSP before the access is aborted with a bus fault (range 2..255)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  execute stage presents a memory op this cycle
mem_read  in  1  decoder load control
mem_write  in  1  decoder store control
funct3  in  3  access size / signedness, RV32 load/store encoding
addr  in  32  effective address (ALU result)
wdata  in  32  store data (rs2)
busy  out  1  pipeline stall request
done  out  1  single-cycle completion pulse
rdata  out  32  formatted load result
fault  out  1  qualifies done: access failed
fault_cause  out  2  01 misaligned, 10 bus timeout, 11 illegal op
bus_req  out  1  bus request
bus_we  out  1  1 = write
bus_addr  out  32  word-aligned address ({addr[31:2],2'b00})
bus_be  out  4  byte enables
bus_wdata  out  32  lane-replicated store data
bus_gnt  in  1  bus accepts the request this cycle
bus_rvalid  in  1  read data valid
bus_rdata  in  32  read data

Behaviour:
- States: IDLE, REQ, WAIT_RSP, DONE. Reset (async): IDLE; all outputs 0; timeout counter 0; latched operands 0.
- IDLE, accept condition: req_valid=1 and (mem_read or mem_write). On acceptance, latch addr, wdata, funct3 and direction.
- IDLE, illegal op: mem_read and mem_write both 1, load funct3=011/110/111, or store funct3[2]=1 -> go to DONE with fault_cause=11.
- IDLE, misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0 -> go to DONE with fault_cause=01.
- IDLE, otherwise -> REQ. Faulted accesses never assert bus_req.
- busy: combinational = (state is REQ or WAIT_RSP) or (state is IDLE and accept condition). busy is 0 in DONE.
- REQ: bus_req=1. bus_we, bus_addr, bus_be and bus_wdata come from the latched values and stay stable until bus_gnt.
- REQ on bus_gnt: store -> DONE; load -> WAIT_RSP. bus_req drops the cycle after gnt.
- WAIT_RSP: wait for bus_rvalid. bus_rvalid is never sampled in the gnt cycle itself.
- On bus_rvalid, register the formatted rdata and go to DONE.
- Timeout counter: cleared on entry to REQ and on entry to WAIT_RSP; increments every cycle spent in those states.
- Timeout: reaching TIMEOUT_CYCLES without the awaited gnt/rvalid -> DONE with fault_cause=10. bus_req deasserts and a late rvalid is ignored.
- DONE: done=1 for exactly one cycle, with fault and fault_cause valid. Always returns to IDLE; a request present in DONE is accepted the following cycle.
- Byte enables: byte 0001<<addr[1:0]; half 0011<<{addr[1],1'b0}; word 1111. Loads drive the same be pattern.
- Store data: SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata. Loads drive bus_wdata=0.
- Load format: lane = bus_rdata >> (8*addr[1:0]).
  - LB: sign-extend lane[7:0]. LBU: zero-extend lane[7:0].
  - LH: sign-extend lane[15:0]. LHU: zero-extend lane[15:0].
  - LW: full word.
- rdata is updated only at load completion (0 on a faulted load) and holds otherwise, including across stores.
- Latency: store accepted at T with gnt at T+1 -> done T+2. Load with gnt T+1 and rvalid T+2 -> done T+3. Faulted op -> done T+1.
- Reset mid-access: bus_req drops immediately (asynchronously); no done pulse; the transaction is abandoned.

Test Plan:
- LB addr=0x1003, bus_rdata=0x80AABBCC -> bus_be=1000, bus_addr=0x1000, done at T+3, rdata=0xFFFFFF80, fault=0.
- LHU addr=0x2002, bus_rdata=0x9ABC1234 -> bus_be=1100, rdata=0x00009ABC. LH same -> rdata=0xFFFF9ABC.
- SB addr=0x10, wdata=0x123456EF, gnt held low 3 cycles -> bus_req and fields stable throughout; bus_be=0001, bus_wdata=0xEFEFEFEF, bus_we=1; done 1 cycle after gnt; busy low in done cycle.
- SW addr=0x6 and LH addr=0x5 -> done at T+1, fault=1, cause=01, bus_req never 1. mem_read=mem_write=1 -> cause=11.
- LW with gnt at T+1 and rvalid never -> done exactly TIMEOUT_CYCLES cycles into WAIT_RSP, cause=10, rdata=0. A later rvalid is ignored and the next request proceeds normally.
- rst pulsed during WAIT_RSP -> bus_req, busy and done all 0 immediately; back-to-back SW then LW after reset complete correctly.
